// File: rtl/io_pkg.sv
// Shared address map and status-word layout for the memory-mapped input block.
package io_pkg;

  localparam logic [1:0] IO_ADDR_SNAP = 2'd0;
  localparam logic [1:0] IO_ADDR_STAT = 2'd1;
  localparam logic [1:0] IO_ADDR_LIVE = 2'd2;
  localparam logic [1:0] IO_ADDR_BTN  = 2'd3;

  localparam int STAT_VALID   = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_CNT_LSB = 8;

  function automatic logic [31:0] stat_word(input logic [7:0] cnt,
                                            input logic       ovr,
                                            input logic       vld);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_LSB +: 8] = cnt;
    w[STAT_OVR]          = ovr;
    w[STAT_VALID]        = vld;
    return w;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// rise_o flags the edge on which the debounced level goes 0->1.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = db_d & ~db_q;

endmodule

// File: rtl/mmio_input_latch.sv
// Switch/button front end for the CPU load path: synchronised switches,
// debounced button, press snapshot with valid/overrun status and a press counter.
module mmio_input_latch
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                button,
  input  logic                rd_en,
  input  logic [1:0]          rd_addr,
  output logic [31:0]         rd_data,
  output logic                btn_valid
);

  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [SW_WIDTH-1:0] snap_q, snap_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic [7:0]          press_cnt_q, press_cnt_d;
  logic                btn_db, press;
  logic                clr_valid, clr_ovr;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (button),
    .db_o   (btn_db),
    .rise_o (press)
  );

  assign clr_valid = rd_en && (rd_addr == IO_ADDR_SNAP);
  assign clr_ovr   = rd_en && (rd_addr == IO_ADDR_STAT);

  // A press beats a same-edge clear: valid stays set, and an overrun set beats its clear.
  always_comb begin
    snap_d      = snap_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;
    press_cnt_d = press_cnt_q;
    if (clr_valid) valid_d = 1'b0;
    if (clr_ovr)   ovr_d   = 1'b0;
    if (press) begin
      snap_d      = sw_sync_q;
      valid_d     = 1'b1;
      press_cnt_d = press_cnt_q + 8'd1;
      if (valid_q && !clr_valid) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      snap_q      <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      sw_meta_q   <= switches;
      sw_sync_q   <= sw_meta_q;
      snap_q      <= snap_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      IO_ADDR_SNAP: rd_data[SW_WIDTH-1:0] = snap_q;
      IO_ADDR_STAT: rd_data = stat_word(press_cnt_q, ovr_q, valid_q);
      IO_ADDR_LIVE: rd_data[SW_WIDTH-1:0] = sw_sync_q;
      IO_ADDR_BTN:  rd_data[0] = btn_db;
      default:      rd_data = '0;
    endcase
  end

  assign btn_valid = valid_q;

endmodule

// File: tb/tb_mmio_input_latch.sv
// Scoreboard bench for mmio_input_latch: expected read words are queued when
// a read is driven and compared when the read data is sampled.
module tb_mmio_input_latch;

  localparam int D = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] switches = '0;
  logic        button = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        btn_valid;

  mmio_input_latch #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .switches  (switches),
    .button    (button),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .btn_valid (btn_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  logic [15:0] m_snap  = '0;
  logic [15:0] m_sw    = '0;
  logic [7:0]  m_cnt   = '0;
  logic        m_valid = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_db    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_snap};
      2'd1:    return {16'h0, m_cnt, 6'b0, m_ovr, m_valid};
      2'd2:    return {16'h0, m_sw};
      default: return {31'h0, m_db};
    endcase
  endfunction

  task automatic sample(input string tag);
    logic [31:0] e;
    #1;
    e = exp_q.pop_front();
    chk(tag, rd_data, e);
  endtask

  task automatic rd(input logic [1:0] a, input bit en, input string tag);
    @(negedge clk);
    rd_en   = en;
    rd_addr = a;
    exp_q.push_back(model_word(a));
    sample(tag);
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (en && a == 2'd0) m_valid = 1'b0;
    if (en && a == 2'd1) m_ovr   = 1'b0;
  endtask

  task automatic set_sw(input logic [15:0] v);
    @(negedge clk);
    switches = v;
    repeat (3) @(posedge clk);
    m_sw = v;
  endtask

  task automatic press(input bit with_rd, input logic [1:0] a);
    @(negedge clk);
    button = 1'b1;
    repeat (D + 1) @(posedge clk);
    @(negedge clk);
    chk("pre_press_valid", {31'b0, btn_valid}, {31'b0, m_valid});
    if (with_rd) begin
      rd_en   = 1'b1;
      rd_addr = a;
      exp_q.push_back(model_word(a));
      sample("press_edge_rd");
    end
    @(posedge clk);
    if (m_valid && !(with_rd && a == 2'd0)) m_ovr = 1'b1;
    else if (with_rd && a == 2'd1)          m_ovr = 1'b0;
    m_valid = 1'b1;
    m_snap  = m_sw;
    m_cnt   = m_cnt + 8'd1;
    m_db    = 1'b1;
    @(negedge clk);
    rd_en   = 1'b0;
    rd_addr = 2'd1;
    exp_q.push_back(model_word(2'd1));
    chk("press_valid", {31'b0, btn_valid}, 32'd1);
    sample("press_status");
  endtask

  task automatic release_btn();
    @(negedge clk);
    button = 1'b0;
    repeat (D + 4) @(posedge clk);
    m_db = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] start_cnt;

    // Reset held with inputs active: everything reads zero.
    rst = 1'b0;
    switches = 16'h1230;
    button = 1'b1;
    repeat (3) @(posedge clk);
    for (int a = 0; a < 4; a++) rd(a[1:0], 1'b0, "rst_read");
    chk("rst_btn_valid", {31'b0, btn_valid}, 32'd0);

    // Button held through reset release: press lands exactly D+2 edges later.
    @(negedge clk);
    rst = 1'b1;
    repeat (D + 1) @(posedge clk);
    @(negedge clk);
    chk("rst_lat_pre", {31'b0, btn_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_lat_post", {31'b0, btn_valid}, 32'd1);
    m_sw = 16'h1230; m_snap = 16'h1230; m_valid = 1'b1; m_cnt = 8'd1; m_db = 1'b1;
    rd(2'd1, 1'b1, "rst_stat");
    chk("rst_stat_const", {16'h0, m_cnt, 6'b0, m_ovr, m_valid}, 32'h0000_0101);
    rd(2'd0, 1'b1, "rst_snap");
    @(negedge clk);
    chk("snap_clr_valid", {31'b0, btn_valid}, 32'd0);
    rd(2'd3, 1'b0, "btn_db_high");
    release_btn();
    rd(2'd3, 1'b0, "btn_db_low");

    // Pulse one cycle short of the debounce window: rejected.
    @(negedge clk);
    button = 1'b1;
    repeat (D - 1) @(posedge clk);
    @(negedge clk);
    button = 1'b0;
    repeat (D + 4) @(posedge clk);
    rd(2'd3, 1'b0, "glitch_db");
    rd(2'd1, 1'b0, "glitch_stat");

    // Bounce: toggle every 5 cycles for 100 cycles, then hold low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      button = ~button;
      repeat (5) @(posedge clk);
    end
    @(negedge clk);
    button = 1'b0;
    repeat (D + 4) @(posedge clk);
    rd(2'd1, 1'b0, "bounce_stat");
    chk("bounce_valid", {31'b0, btn_valid}, 32'd0);

    // Switch latency: old value after one edge, new after two.
    @(negedge clk);
    switches = 16'hBEEF;
    rd_addr  = 2'd2;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(model_word(2'd2));
    sample("sw_lat_1");
    @(posedge clk);
    @(negedge clk);
    m_sw = 16'hBEEF;
    exp_q.push_back(model_word(2'd2));
    sample("sw_lat_2");

    // Normal handshake.
    set_sw(16'h00A5);
    press(1'b0, 2'd0);
    rd(2'd0, 1'b1, "hs_snap");
    @(negedge clk);
    chk("hs_valid_clr", {31'b0, btn_valid}, 32'd0);
    release_btn();
    set_sw(16'h005A);
    press(1'b0, 2'd0);
    release_btn();
    rd(2'd1, 1'b0, "hs_stat");

    // Overrun: two presses with no clearing read between them.
    rd(2'd0, 1'b1, "ovr_pre_clr");
    press(1'b0, 2'd0);
    release_btn();
    press(1'b0, 2'd0);
    release_btn();
    rd(2'd1, 1'b1, "ovr_stat");
    rd(2'd1, 1'b1, "ovr_cleared");

    // Press coinciding with an addr-0 read: press wins, overrun untouched.
    set_sw(16'h0F0F);
    press(1'b1, 2'd0);
    release_btn();
    rd(2'd1, 1'b0, "sim0_stat");
    rd(2'd0, 1'b0, "sim0_snap");

    // Press coinciding with an addr-1 read while valid: overrun set wins.
    press(1'b1, 2'd1);
    release_btn();
    rd(2'd1, 1'b0, "sim1_stat");

    // 256 presses wrap the 8-bit counter back to where it started.
    start_cnt = m_cnt;
    for (int i = 0; i < 256; i++) begin
      press(1'b0, 2'd0);
      release_btn();
    end
    rd(2'd1, 1'b0, "wrap_stat");
    @(negedge clk);
    rd_addr = 2'd1;
    #1;
    chk("wrap_cnt", {24'h0, rd_data[15:8]}, {24'h0, start_cnt});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_input_latch.md
# mmio_input_latch

Memory-mapped input front end between the board's raw switches/button and the pipelined CPU's MEM-stage load path. It synchronises the 16 switches, synchronises and debounces the button, and snapshots the switches on each debounced press. Each press raises a valid flag, which the CPU clears by a load from the snapshot address. It also keeps a press counter and an overrun flag for presses that arrive before the previous snapshot was consumed.

## Interface
- `DEBOUNCE_CYCLES`, default 20 (sim; board build uses 1_000_000): consecutive stable cycles required to accept a button change; must be ≥2.
- `SW_WIDTH`, default 16: switch bus width.

Ports:
- `clk`  in  1  CPU clock. One clock domain. All state changes on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low: rst=0 clears all state immediately.
- `switches`  in  SW_WIDTH  raw board switches, asynchronous.
- `button`  in  1  raw push button, asynchronous, bouncy.
- `rd_en`  in  1  MEM-stage load strobe to this block's address range. One cycle per load.
- `rd_addr`  in  2  word select within the block.
- `rd_data`  out  32  combinational read data for `rd_addr`.
- `btn_valid`  out  1  the snapshot-valid flag, for an LED or polling.

## Operation
- **Switches**: 2-flop synchroniser to `sw_sync`. No debounce.
- **Button**: 2-flop synchroniser to `btn_sync`, then the debouncer.
  - `cnt` clears to 0 whenever `btn_sync` equals `btn_db`.
  - While they differ, `cnt` increments each edge.
  - On an edge where they differ and `cnt` equals DEBOUNCE_CYCLES−1, `btn_db` takes `btn_sync` and `cnt` clears.
- **Press event**: the edge at which `btn_db` goes 0→1. On that edge:
  - `snapshot` ← `sw_sync`
  - `valid` ← 1
  - `press_cnt` ← `press_cnt` + 1 (8-bit, wraps 255→0)
  - `overrun` ← 1 if `valid` was already 1 and this edge is not a clearing read.
- A button release (1→0) has no side effect.
- **Read map** (combinational; unused bits are 0):
  - addr 0: {0, `snapshot`}
  - addr 1: {16'b0, `press_cnt`[15:8], 6'b0, `overrun`[1], `valid`[0]}
  - addr 2: {0, `sw_sync`}
  - addr 3: {31'b0, `btn_db`}
- **Read side effects**, on the edge where `rd_en`=1:
  - addr 0 clears `valid`.
  - addr 1 clears `overrun`.
  - addr 2 and addr 3 have none.
- **Simultaneous events**:
  - Press and addr-0 read on the same edge: the press wins. `valid` stays 1, `snapshot` takes the new value, `overrun` is unchanged.
  - Press and addr-1 read on the same edge, with `valid` already 1: `overrun` ends at 1, because the set wins over the clear.
- `btn_valid` equals `valid`.

## Timing
- Reset values: both synchronisers 0, `btn_db` 0, `cnt` 0, `snapshot` 0, `valid` 0, `overrun` 0, `press_cnt` 0. As a result `rd_data` = 0 for every address and `btn_valid` = 0.
- **Press latency**: if `button` is high before edge k and stays high, `valid`=1 after edge k+1+DEBOUNCE_CYCLES.
- **Glitch rejection**: a high pulse on `btn_sync` shorter than DEBOUNCE_CYCLES cycles restarts `cnt` and produces no event.
- **Switch latency**: a `switches` change is visible at addr 2 two edges later. `snapshot` captures `sw_sync`, not raw `switches`.
- **Read clear latency**: a clearing read takes effect on the same edge. The next cycle reads the cleared value.
- **Reset mid-debounce**: all progress is discarded. A button still held when rst releases produces a press DEBOUNCE_CYCLES+2 edges after release.
- **Counter width**: `cnt` is wide enough for DEBOUNCE_CYCLES−1 and never exceeds it.

## Structure
- Shared package `io_pkg` holds:
  - address constants `IO_ADDR_SNAP`=0, `IO_ADDR_STAT`=1, `IO_ADDR_LIVE`=2, `IO_ADDR_BTN`=3
  - status bit positions `STAT_VALID`=0, `STAT_OVR`=1, `STAT_CNT_LSB`=8.
- Sub-module `debounce_sync`: 2-flop synchroniser plus the debounce counter, parameterised by DEBOUNCE_CYCLES. Instantiated once, for the button.
- The top block holds the switch synchroniser, press detection, status registers and the read mux.

## Test plan
- **Reset**: hold rst=0 while driving switches=16'h1230 and button=1 → all `rd_data` reads return 0 and `btn_valid`=0. Release rst with the button still held → `valid`=1 exactly DEBOUNCE_CYCLES+2 edges later, addr 0 reads 32'h00001230, addr 1 reads 32'h00000101.
- **Bounce rejection**: toggle button every 5 cycles for 100 cycles (DEBOUNCE_CYCLES=20), then hold it low → no press, and addr 1 reads 0.
- **Normal handshake**: switches=16'h00A5, press, then addr-0 read → read returns 32'h000000A5 and `valid`=0 the next cycle. Release and press again with switches=16'h005A → `press_cnt`=2, `overrun`=0.
- **Overrun**: two presses with no read in between → addr 1 reads 32'h00000203. A following addr-1 read clears `overrun`, and the next addr-1 read returns 32'h00000201.
- **Simultaneous**: align an addr-0 read with the press edge → `valid` stays 1 and `snapshot` holds the new switches. Then drive 256 presses and check `press_cnt` wraps back to its starting value.
